// File: rtl/aes_round_ctrl.sv
// Iterative AES encryption round controller with its combinational
// round modules; one full round per clock, round keys fetched by index.

module sub_bytes (
   input  logic [127:0] din,
   output logic [127:0] dout
);
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Entry 0 sits in the top byte, so the index is inverted.
   for (genvar i = 0; i < 16; i++) begin : g_sb
      assign dout[8*i +: 8] = SBOX[{~din[8*i +: 8], 3'b000} +: 8];
   end
endmodule

module shift_rows (
   input  logic [127:0] din,
   output logic [127:0] dout
);
   // Byte 4c+r holds row r of column c; row r rotates left by r.
   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign dout[127-8*(4*c+r) -: 8] =
            din[127-8*(4*((c+r)%4)+r) -: 8];
      end
   end
endmodule

module mix_columns (
   input  logic [127:0] din,
   output logic [127:0] dout
);
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   for (genvar c = 0; c < 4; c++) begin : g_col
      logic [7:0] a0, a1, a2, a3;
      assign a0 = din[127-32*c -: 8];
      assign a1 = din[119-32*c -: 8];
      assign a2 = din[111-32*c -: 8];
      assign a3 = din[103-32*c -: 8];
      assign dout[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      assign dout[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      assign dout[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      assign dout[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
   end
endmodule

module add_round_key (
   input  logic [127:0] din,
   input  logic [127:0] rkey,
   output logic [127:0] dout
);
   assign dout = din ^ rkey;
endmodule

module aes_round_ctrl #(
   parameter int NK = 4
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_start,
   input  logic [127:0] i_plaintext,
   input  logic [127:0] i_round_key,
   output logic [3:0]   o_rk_index,
   output logic         o_busy,
   output logic         o_done,
   output logic [127:0] o_ciphertext
);
   localparam int NR = NK + 6;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ROUND = 2'd1;
   localparam logic [1:0] S_FINAL = 2'd2;

   if (NK != 4 && NK != 6 && NK != 8) begin : g_nk_check
      $error("aes_round_ctrl: NK must be 4, 6 or 8");
   end

   logic [1:0]   fsm;
   logic [3:0]   rnd;
   logic [127:0] st;
   logic [127:0] sb_out, sr_out, mc_out;
   logic [127:0] ark_in, ark_out;

   sub_bytes     u_sb  (.din(st),     .dout(sb_out));
   shift_rows    u_sr  (.din(sb_out), .dout(sr_out));
   mix_columns   u_mc  (.din(sr_out), .dout(mc_out));
   add_round_key u_ark (.din(ark_in), .rkey(i_round_key), .dout(ark_out));

   // IDLE whitens the plaintext; FINAL skips MixColumns.
   always_comb begin
      ark_in     = i_plaintext;
      o_rk_index = 4'd0;
      unique case (fsm)
         S_ROUND: begin
            ark_in     = mc_out;
            o_rk_index = rnd;
         end
         S_FINAL: begin
            ark_in     = sr_out;
            o_rk_index = 4'(NR);
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         fsm    <= S_IDLE;
         rnd    <= '0;
         st     <= '0;
         o_busy <= 1'b0;
         o_done <= 1'b0;
      end else begin
         o_done <= 1'b0;
         unique case (fsm)
            S_IDLE: begin
               if (i_start) begin
                  st     <= ark_out;
                  rnd    <= 4'd1;
                  o_busy <= 1'b1;
                  fsm    <= S_ROUND;
               end
            end
            S_ROUND: begin
               st  <= ark_out;
               rnd <= rnd + 4'd1;
               if (rnd == 4'(NR - 1)) fsm <= S_FINAL;
            end
            S_FINAL: begin
               st     <= ark_out;
               rnd    <= '0;
               o_busy <= 1'b0;
               o_done <= 1'b1;
               fsm    <= S_IDLE;
            end
            default: fsm <= S_IDLE;
         endcase
      end
   end

   assign o_ciphertext = st;
endmodule

// File: tb/tb_aes_round_ctrl.sv
// Scoreboard bench for aes_round_ctrl: AES-128 and AES-256 instances,
// FIPS-197 vectors, handshake corner cases and mid-run reset.

module tb_aes_round_ctrl;
   localparam int NR4 = 10;
   localparam int NR8 = 14;

   localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] R2_C1  = 128'h89d810e8855ace682d1843d8cb128fe4;
   localparam logic [255:0] KEY_C3 =
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

   typedef struct {
      logic [127:0] ct;
      int           acc;
   } exp_t;

   logic clk = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   logic         rst4, st4, busy4, done4;
   logic [127:0] pt4, rk4, ct4;
   logic [3:0]   idx4;
   logic         rst8, st8, busy8, done8;
   logic [127:0] pt8, rk8, ct8;
   logic [3:0]   idx8;

   logic [127:0] ks4 [15];
   logic [127:0] ks8 [15];
   logic [7:0]   sbt [256];
   exp_t         q4[$];
   exp_t         q8[$];
   exp_t         e4, e8;
   int           a;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign rk4 = ks4[idx4];
   assign rk8 = ks8[idx8];

   aes_round_ctrl #(.NK(4)) dut4 (
      .i_clk(clk), .i_rst(rst4), .i_start(st4),
      .i_plaintext(pt4), .i_round_key(rk4),
      .o_rk_index(idx4), .o_busy(busy4), .o_done(done4),
      .o_ciphertext(ct4)
   );

   aes_round_ctrl #(.NK(8)) dut8 (
      .i_clk(clk), .i_rst(rst8), .i_start(st8),
      .i_plaintext(pt8), .i_round_key(rk8),
      .o_rk_index(idx8), .o_busy(busy8), .o_done(done8),
      .o_ciphertext(ct8)
   );

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] x0,
                                       input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = x0;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // S-box from the field inverse plus affine map, independent of any table.
   function automatic logic [7:0] sbox_calc(input logic [7:0] x);
      logic [7:0] v;
      v = 8'h00;
      for (int i = 1; i < 256; i++)
         if (gmul(x, 8'(i)) == 8'h01) v = 8'(i);
      return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
               ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sbt[w[31:24]], sbt[w[23:16]], sbt[w[15:8]], sbt[w[7:0]]};
   endfunction

   task automatic load_keys(input logic [255:0] key, input int nk);
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rc;
      int          nw;
      nw = 4 * (nk + 7);
      rc = 8'h01;
      for (int i = 0; i < nw; i++) begin
         if (i < nk) begin
            w[i] = key[255-32*i -: 32];
         end else begin
            t = w[i-1];
            if (i % nk == 0) begin
               t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
               rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
               t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
         end
      end
      for (int r = 0; r <= nk + 6; r++) begin
         if (nk == 4) ks4[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
         else         ks8[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      end
   endtask

   task automatic start4(input logic [127:0] pt, input logic [127:0] ct);
      st4 = 1'b1;
      pt4 = pt;
      q4.push_back('{ct: ct, acc: cyc + 1});
      @(negedge clk);
      st4 = 1'b0;
      pt4 = {$urandom(), $urandom(), $urandom(), $urandom()};
   endtask

   task automatic drain(input int budget);
      int i;
      i = 0;
      while ((q4.size() != 0 || q8.size() != 0) && i < budget) begin
         @(negedge clk);
         i++;
      end
      chk("drain", 128'(q4.size() + q8.size()), 128'd0);
   endtask

   always @(negedge clk) begin
      if (done4) begin
         chk("done4_expected", 128'(q4.size() > 0), 128'd1);
         if (q4.size() > 0) begin
            e4 = q4.pop_front();
            chk("ct4", ct4, e4.ct);
            chk("lat4", 128'(cyc - e4.acc), 128'(NR4));
         end
      end
      if (done8) begin
         chk("done8_expected", 128'(q8.size() > 0), 128'd1);
         if (q8.size() > 0) begin
            e8 = q8.pop_front();
            chk("ct8", ct8, e8.ct);
            chk("lat8", 128'(cyc - e8.acc), 128'(NR8));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not complete");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 256; i++) sbt[i] = sbox_calc(8'(i));
      rst4 = 1'b1; st4 = 1'b0; pt4 = '0;
      rst8 = 1'b1; st8 = 1'b0; pt8 = '0;
      load_keys({KEY_B, 128'h0}, 4);
      load_keys(KEY_C3, 8);
      repeat (2) @(negedge clk);
      chk("rst_busy4", 128'(busy4), 128'd0);
      chk("rst_done4", 128'(done4), 128'd0);
      chk("rst_ct4", ct4, 128'd0);
      chk("rst_idx4", 128'(idx4), 128'd0);
      chk("rst_busy8", 128'(busy8), 128'd0);
      chk("rst_ct8", ct8, 128'd0);
      rst4 = 1'b0;
      rst8 = 1'b0;
      @(negedge clk);

      // App. B
      start4(PT_B, CT_B);
      drain(30);

      // App. C.1 with index trace and early round states
      load_keys({KEY_C1, 128'h0}, 4);
      chk("idx_pre", 128'(idx4), 128'd0);
      start4(PT_C1, CT_C1);
      for (int j = 0; j <= 10; j++) begin
         chk($sformatf("idx_%0d", j), 128'(idx4),
             128'((j == 10) ? 0 : j + 1));
         chk($sformatf("busy_%0d", j), 128'(busy4), 128'(j < 10));
         if (j == 0) chk("st_r0", ct4, PT_C1 ^ KEY_C1);
         if (j == 1) chk("st_r1", ct4, R2_C1);
         if (j < 10) @(negedge clk);
      end
      drain(5);

      // start during round 5 is ignored; start in the done cycle is taken
      load_keys({KEY_B, 128'h0}, 4);
      start4(PT_B, CT_B);
      a = cyc;
      repeat (4) @(negedge clk);
      st4 = 1'b1;
      pt4 = PT_C1;
      @(negedge clk);
      st4 = 1'b0;
      chk("busy_ign", 128'(busy4), 128'd1);
      repeat (5) @(negedge clk);
      chk("done_at_10", 128'(done4), 128'd1);
      load_keys({KEY_C1, 128'h0}, 4);
      start4(PT_C1, CT_C1);
      chk("busy_nogap", 128'(busy4), 128'd1);
      chk("done_fall", 128'(done4), 128'd0);
      drain(20);

      // reset during round 4
      load_keys({KEY_B, 128'h0}, 4);
      start4(PT_B, CT_B);
      repeat (3) @(negedge clk);
      rst4 = 1'b1;
      q4.delete();
      @(negedge clk);
      rst4 = 1'b0;
      chk("mid_rst_busy", 128'(busy4), 128'd0);
      chk("mid_rst_ct", ct4, 128'd0);
      chk("mid_rst_done", 128'(done4), 128'd0);
      chk("mid_rst_idx", 128'(idx4), 128'd0);
      repeat (12) @(negedge clk);
      start4(PT_B, CT_B);
      drain(20);

      // held start: three runs, 11 cycles apart
      load_keys({KEY_C1, 128'h0}, 4);
      st4 = 1'b1;
      pt4 = PT_C1;
      for (int n = 0; n < 3; n++)
         q4.push_back('{ct: CT_C1, acc: cyc + 1 + 11 * n});
      repeat (23) @(negedge clk);
      st4 = 1'b0;
      drain(20);

      // App. C.3, AES-256
      st8 = 1'b1;
      pt8 = PT_C1;
      q8.push_back('{ct: CT_C3, acc: cyc + 1});
      @(negedge clk);
      st8 = 1'b0;
      pt8 = '0;
      drain(30);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end
endmodule
